image_flip_invert_ctrl: RTL and testbench
=========================================

// Module: image_flip_invert_ctrl
// PURPOSE
//  Sequencer that drives the 2-read/2-write image RAM (DW_ram_2r_2w_s_dff) to mirror each
//  row horizontally and optionally invert colour, in place. Pixels are processed as
//  outside-in pairs: read both, then write each to the other's address. Sits between the
//  top-level start/done handshake and the RAM ports; owns all RAM enables and addresses.
// PARAMETERS
//  IMG_W      320  pixels per row (>=1, odd allowed)
//  IMG_H      240  rows (>=1)
//  ADDR_W     17   RAM address width
//  DATA_W     32   RAM word width
//  PIX_W      24   valid pixel bits {R,G,B}, 8 bits each, in word[PIX_W-1:0]
//  BASE_ADDR  0    word address of pixel (row 0, col 0); pixel (r,c) at BASE_ADDR+r*IMG_W+c
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset_n    in   1       asynchronous active-low reset
//  start      in   1       begin a frame; sampled only in IDLE
//  abort      in   1       stop the frame early (see BEHAVIOUR)
//  invert_en  in   1       1: write 255-x per channel; 0: flip only; latched at start
//  busy       out  1       high from the cycle after start accepted until return to IDLE
//  done       out  1       high after full frame; held until next accepted start
//  en_r1_n    out  1       RAM read port 1 enable, active low
//  addr_r1    out  ADDR_W  read port 1 address (left pixel)
//  data_r1    in   DATA_W  read port 1 data, combinational from addr_r1
//  en_r2_n    out  1       RAM read port 2 enable, active low
//  addr_r2    out  ADDR_W  read port 2 address (right pixel)
//  data_r2    in   DATA_W  read port 2 data, combinational from addr_r2
//  en_w1_n/addr_w1/data_w1  out 1/ADDR_W/DATA_W  write port 1 (written at left address)
//  en_w2_n/addr_w2/data_w2  out 1/ADDR_W/DATA_W  write port 2 (written at right address)
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, all en_*_n=1, all addr/data outputs 0, counters 0.
//  States: IDLE -> RD -> WR -> (RD | FIN) ; FIN -> IDLE. All enables registered outputs.
//  IDLE: start=1 -> latch invert_en, row=0, col=0, done<=0, busy<=1, go RD.
//  RD (1 cycle): en_r1_n=0, addr_r1=row_base+col; en_r2_n=0, addr_r2=row_base+IMG_W-1-col
//   unless middle pixel (col==IMG_W-1-col): then en_r2_n=1. data_r1/r2 captured at edge.
//  WR (1 cycle): en_w1_n=0, addr_w1=left, data_w1=f(captured r2); en_w2_n=0,
//   addr_w2=right, data_w2=f(captured r1). Middle pixel: en_w2_n=1, w1 writes f(r1) to
//   itself. f: per 8-bit channel 255-x if invert latched else x; bits above PIX_W = 0.
//  Pair advance in WR: col<ceil(IMG_W/2)-1 -> col+1; else col=0, row+1, row_base+=IMG_W
//   (adder, no multiplier). Last pair of row IMG_H-1 -> FIN.
//  FIN: done<=1, busy<=0, all enables high, go IDLE.
//  Throughput: 2 cycles/pair; start accepted at edge k -> done visible after edge
//   k+2*IMG_H*ceil(IMG_W/2)+1 (320x240: 76801 cycles).
//  Never enable a read and write in the same cycle; both write ports never same address.
//  abort=1 in RD: no write for that pair, go IDLE, busy=0, done stays 0. In WR: finish
//   current writes, then IDLE, done=0. Ignored in IDLE/FIN. Abort wins over last-pair FIN.
//  start while busy: ignored. start and abort both high in IDLE: start ignored.
//  reset_n low mid-frame: immediate reset values; partially processed frame left as is.
// TESTING
//  1 IMG_W=4,IMG_H=2, mem 0..7=0x000000..0x000007, invert=0 -> mem = 3,2,1,0,7,6,5,4;
//    done after exactly 9 cycles; busy high 8 cycles.
//  2 Same, invert=1, word0=0xFF102030 -> word3 becomes 0x00EFDFCF (upper byte zeroed).
//  3 IMG_W=5,IMG_H=1, mem=A,B,C,D,E, invert=1 -> ~E,~D,~C,~B,~A; middle cycle en_r2_n=1,
//    en_w2_n=1.
//  4 320x240 frame from image file, invert=1 -> matches golden flipped/inverted image;
//    done at 76801 cycles; assertion: no read/write enables overlap, w1!=w2 addr.
//  5 abort raised in RD of pair 3 (W=4,H=2) -> rows 0 complete, row1 untouched, done=0,
//    busy=0 next cycle; new start then completes frame correctly.
//  6 reset_n pulsed low mid-frame -> all enables 1, busy=0, done=0 asynchronously; start
//    after release runs a full frame; start while busy has no effect on cycle count.

Source files
------------

// File: rtl/image_flip_invert_ctrl_if.sv
// image_flip_invert_ctrl_if
//   Bundles the start/done handshake of the flip/invert sequencer together with
//   the two read ports and two write ports of the image RAM it drives.
//   master : the sequencer (consumes start/abort/invert_en and read data,
//            drives busy/done and every RAM enable, address and write word)
//   slave  : the surrounding system (host handshake plus the RAM itself)
interface image_flip_invert_ctrl_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
);
    logic              start;
    logic              abort;
    logic              invert_en;
    logic              busy;
    logic              done;
    logic              en_r1_n;
    logic [ADDR_W-1:0] addr_r1;
    logic [DATA_W-1:0] data_r1;
    logic              en_r2_n;
    logic [ADDR_W-1:0] addr_r2;
    logic [DATA_W-1:0] data_r2;
    logic              en_w1_n;
    logic [ADDR_W-1:0] addr_w1;
    logic [DATA_W-1:0] data_w1;
    logic              en_w2_n;
    logic [ADDR_W-1:0] addr_w2;
    logic [DATA_W-1:0] data_w2;

    modport master (
        input  start, abort, invert_en, data_r1, data_r2,
        output busy, done,
        output en_r1_n, addr_r1, en_r2_n, addr_r2,
        output en_w1_n, addr_w1, data_w1, en_w2_n, addr_w2, data_w2
    );

    modport slave (
        output start, abort, invert_en, data_r1, data_r2,
        input  busy, done,
        input  en_r1_n, addr_r1, en_r2_n, addr_r2,
        input  en_w1_n, addr_w1, data_w1, en_w2_n, addr_w2, data_w2
    );
endinterface

// File: rtl/image_flip_invert_ctrl.sv
// image_flip_invert_ctrl
//   Sequencer that mirrors every image row in place (and optionally inverts each
//   8-bit colour channel) using a 2-read/2-write RAM. Pixels are handled as
//   outside-in pairs: one RD cycle fetches both, one WR cycle writes each to the
//   other's address. The middle pixel of an odd-width row is read on port 1 only
//   and written back to itself on port 1 only.
// Ports
//   clk      : clock, all state on the rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : master side of image_flip_invert_ctrl_if
//              start/abort/invert_en in, busy/done out,
//              read ports r1 (left pixel) / r2 (right pixel), combinational data in,
//              write ports w1 (left address) / w2 (right address); enables active low.
module image_flip_invert_ctrl #(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 32,
    parameter int PIX_W     = 24,
    parameter int BASE_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    image_flip_invert_ctrl_if.master bus
);

    localparam int HALF  = (IMG_W + 1) / 2;
    localparam int COL_W = (HALF  > 1) ? $clog2(HALF)  : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam bit ODD_W = (IMG_W % 2) == 1;

    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(HALF - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] RIGHT_OFF = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // Per-channel transform; bits above PIX_W are always cleared.
    function automatic logic [DATA_W-1:0] pix_f(input logic [DATA_W-1:0] x, input logic inv);
        logic [DATA_W-1:0] y;
        y = '0;
        for (int ch = 0; ch < PIX_W / 8; ch++) begin
            y[ch*8 +: 8] = inv ? (8'hFF - x[ch*8 +: 8]) : x[ch*8 +: 8];
        end
        return y;
    endfunction

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic               inv_q, inv_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               en_r1_n_q, en_r1_n_d;
    logic               en_r2_n_q, en_r2_n_d;
    logic               en_w1_n_q, en_w1_n_d;
    logic               en_w2_n_q, en_w2_n_d;
    logic [ADDR_W-1:0]  addr_r1_q, addr_r1_d;
    logic [ADDR_W-1:0]  addr_r2_q, addr_r2_d;
    logic [ADDR_W-1:0]  addr_w1_q, addr_w1_d;
    logic [ADDR_W-1:0]  addr_w2_q, addr_w2_d;
    logic [DATA_W-1:0]  data_w1_q, data_w1_d;
    logic [DATA_W-1:0]  data_w2_q, data_w2_d;
    logic [ADDR_W-1:0]  left_d, right_d;
    logic               mid_d;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        inv_d      = inv_q;
        done_d     = done_q;

        unique case (state_q)
            S_IDLE: begin
                // abort takes priority over a simultaneous start
                if (bus.start && !bus.abort) begin
                    inv_d      = bus.invert_en;
                    col_d      = '0;
                    row_d      = '0;
                    row_base_d = '0;
                    done_d     = 1'b0;
                    state_d    = S_RD;
                end
            end
            S_RD: begin
                state_d = bus.abort ? S_IDLE : S_WR;
            end
            S_WR: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (col_q == LAST_COL) begin
                    if (row_q == LAST_ROW) begin
                        state_d = S_FIN;
                    end else begin
                        col_d      = '0;
                        row_d      = row_q + 1'b1;
                        row_base_d = row_base_q + ROW_STEP;
                        state_d    = S_RD;
                    end
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = S_RD;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // All RAM controls are registered, so they are computed for the state being
        // entered. Counters do not move between RD and WR, so the pair addresses
        // derived from the next counters serve both cycles.
        busy_d  = (state_d == S_RD) || (state_d == S_WR);
        mid_d   = ODD_W && (col_d == LAST_COL);
        left_d  = BASE_A + row_base_d + ADDR_W'(col_d);
        right_d = BASE_A + row_base_d + RIGHT_OFF - ADDR_W'(col_d);

        en_r1_n_d = 1'b1;
        en_r2_n_d = 1'b1;
        en_w1_n_d = 1'b1;
        en_w2_n_d = 1'b1;
        addr_r1_d = addr_r1_q;
        addr_r2_d = addr_r2_q;
        addr_w1_d = addr_w1_q;
        addr_w2_d = addr_w2_q;
        data_w1_d = data_w1_q;
        data_w2_d = data_w2_q;

        if (state_d == S_RD) begin
            en_r1_n_d = 1'b0;
            addr_r1_d = left_d;
            en_r2_n_d = mid_d;
            if (!mid_d) begin
                addr_r2_d = right_d;
            end
        end

        // WR is only entered from RD, so the read data is live on this edge.
        if (state_d == S_WR) begin
            en_w1_n_d = 1'b0;
            addr_w1_d = left_d;
            data_w1_d = pix_f(mid_d ? bus.data_r1 : bus.data_r2, inv_q);
            en_w2_n_d = mid_d;
            if (!mid_d) begin
                addr_w2_d = right_d;
                data_w2_d = pix_f(bus.data_r1, inv_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            inv_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            en_r1_n_q  <= 1'b1;
            en_r2_n_q  <= 1'b1;
            en_w1_n_q  <= 1'b1;
            en_w2_n_q  <= 1'b1;
            addr_r1_q  <= '0;
            addr_r2_q  <= '0;
            addr_w1_q  <= '0;
            addr_w2_q  <= '0;
            data_w1_q  <= '0;
            data_w2_q  <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            inv_q      <= inv_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            en_r1_n_q  <= en_r1_n_d;
            en_r2_n_q  <= en_r2_n_d;
            en_w1_n_q  <= en_w1_n_d;
            en_w2_n_q  <= en_w2_n_d;
            addr_r1_q  <= addr_r1_d;
            addr_r2_q  <= addr_r2_d;
            addr_w1_q  <= addr_w1_d;
            addr_w2_q  <= addr_w2_d;
            data_w1_q  <= data_w1_d;
            data_w2_q  <= data_w2_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.en_r1_n = en_r1_n_q;
    assign bus.en_r2_n = en_r2_n_q;
    assign bus.en_w1_n = en_w1_n_q;
    assign bus.en_w2_n = en_w2_n_q;
    assign bus.addr_r1 = addr_r1_q;
    assign bus.addr_r2 = addr_r2_q;
    assign bus.addr_w1 = addr_w1_q;
    assign bus.addr_w2 = addr_w2_q;
    assign bus.data_w1 = data_w1_q;
    assign bus.data_w2 = data_w2_q;

endmodule

// File: tb/tb_image_flip_invert_ctrl.sv
module tb_image_flip_invert_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic start = 1'b0;
    logic abort = 1'b0;
    logic invert_en = 1'b0;
    int   sel = 0;

    image_flip_invert_ctrl_if #(.ADDR_W(8), .DATA_W(32)) ifa ();
    image_flip_invert_ctrl_if #(.ADDR_W(8), .DATA_W(32)) ifb ();

    image_flip_invert_ctrl #(.IMG_W(4), .IMG_H(2), .ADDR_W(8), .DATA_W(32), .PIX_W(24), .BASE_ADDR(0))
        ua (.clk(clk), .reset_n(reset_n), .bus(ifa));
    image_flip_invert_ctrl #(.IMG_W(5), .IMG_H(1), .ADDR_W(8), .DATA_W(32), .PIX_W(24), .BASE_ADDR(0))
        ub (.clk(clk), .reset_n(reset_n), .bus(ifb));

    assign ifa.start     = start && (sel == 0);
    assign ifb.start     = start && (sel == 1);
    assign ifa.abort     = abort && (sel == 0);
    assign ifb.abort     = abort && (sel == 1);
    assign ifa.invert_en = invert_en;
    assign ifb.invert_en = invert_en;

    // RAM model: combinational reads, writes on the rising edge
    logic [31:0] mem [2][8];
    logic [31:0] img [8];
    logic        load = 1'b0;

    assign ifa.data_r1 = mem[0][ifa.addr_r1[2:0]];
    assign ifa.data_r2 = mem[0][ifa.addr_r2[2:0]];
    assign ifb.data_r1 = mem[1][ifb.addr_r1[2:0]];
    assign ifb.data_r2 = mem[1][ifb.addr_r2[2:0]];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 8; i++) mem[sel][i] <= img[i];
        end else begin
            if (!ifa.en_w1_n) mem[0][ifa.addr_w1[2:0]] <= ifa.data_w1;
            if (!ifa.en_w2_n) mem[0][ifa.addr_w2[2:0]] <= ifa.data_w2;
            if (!ifb.en_w1_n) mem[1][ifb.addr_w1[2:0]] <= ifb.data_w1;
            if (!ifb.en_w2_n) mem[1][ifb.addr_w2[2:0]] <= ifb.data_w2;
        end
    end

    int cyc_all = 0;
    always @(posedge clk) cyc_all <= cyc_all + 1;

    // view of the instance under test
    logic busy_s, done_s, en_r1_s, en_r2_s, en_w1_s, en_w2_s;
    logic [7:0]  addr_r1_s, addr_r2_s, addr_w1_s, addr_w2_s;
    logic [31:0] data_w1_s, data_w2_s;
    assign busy_s    = (sel == 0) ? ifa.busy    : ifb.busy;
    assign done_s    = (sel == 0) ? ifa.done    : ifb.done;
    assign en_r1_s   = (sel == 0) ? ifa.en_r1_n : ifb.en_r1_n;
    assign en_r2_s   = (sel == 0) ? ifa.en_r2_n : ifb.en_r2_n;
    assign en_w1_s   = (sel == 0) ? ifa.en_w1_n : ifb.en_w1_n;
    assign en_w2_s   = (sel == 0) ? ifa.en_w2_n : ifb.en_w2_n;
    assign addr_r1_s = (sel == 0) ? ifa.addr_r1 : ifb.addr_r1;
    assign addr_r2_s = (sel == 0) ? ifa.addr_r2 : ifb.addr_r2;
    assign addr_w1_s = (sel == 0) ? ifa.addr_w1 : ifb.addr_w1;
    assign addr_w2_s = (sel == 0) ? ifa.addr_w2 : ifb.addr_w2;
    assign data_w1_s = (sel == 0) ? ifa.data_w1 : ifb.data_w1;
    assign data_w2_s = (sel == 0) ? ifa.data_w2 : ifb.data_w2;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // expected pixel transform: 255-x per 8-bit channel when inverting, top byte zero
    function automatic logic [31:0] fm(input logic [31:0] x, input bit inv);
        logic [31:0] y;
        int v;
        y = 32'h0;
        for (int ch = 0; ch < 3; ch++) begin
            v = int'(x[ch*8 +: 8]);
            y[ch*8 +: 8] = 8'(inv ? 255 - v : v);
        end
        return y;
    endfunction

    task automatic inv_chk(input string tag, input logic r1, input logic r2, input logic w1,
                           input logic w2, input logic [7:0] a1, input logic [7:0] a2);
        chk({tag, "_rd_wr_overlap"}, 32'((!r1 || !r2) && (!w1 || !w2)), 32'd0);
        chk({tag, "_w1_w2_same_addr"}, 32'(!w1 && !w2 && (a1 == a2)), 32'd0);
    endtask

    // behavioural model of a frame, indexed by cycles since the accepting edge
    logic [31:0] orig [8];
    bit trk = 1'b0;
    bit inv_m = 1'b0;
    int k_cyc = 0;

    always @(negedge clk) begin : cmp
        int t, p, r, c, w, h, half, np, lft, rgt;
        bit mid;
        if (reset_n) begin
            inv_chk("a", ifa.en_r1_n, ifa.en_r2_n, ifa.en_w1_n, ifa.en_w2_n, ifa.addr_w1, ifa.addr_w2);
            inv_chk("b", ifb.en_r1_n, ifb.en_r2_n, ifb.en_w1_n, ifb.en_w2_n, ifb.addr_w1, ifb.addr_w2);
        end
        if (trk) begin
            w = (sel == 0) ? 4 : 5;
            h = (sel == 0) ? 2 : 1;
            half = (w + 1) / 2;
            np = h * half;
            t = cyc_all - k_cyc + 1;
            if (t >= 1 && t <= 2 * np) begin
                p = (t - 1) / 2;
                r = p / half;
                c = p % half;
                lft = r * w + c;
                rgt = r * w + w - 1 - c;
                mid = (lft == rgt);
                chk("m_busy", 32'(busy_s), 32'd1);
                chk("m_done", 32'(done_s), 32'd0);
                if (t % 2 == 1) begin
                    chk("m_rd_en_r1", 32'(en_r1_s), 32'd0);
                    chk("m_rd_addr_r1", 32'(addr_r1_s), 32'(lft));
                    chk("m_rd_en_r2", 32'(en_r2_s), 32'(mid));
                    if (!mid) chk("m_rd_addr_r2", 32'(addr_r2_s), 32'(rgt));
                    chk("m_rd_en_w1", 32'(en_w1_s), 32'd1);
                    chk("m_rd_en_w2", 32'(en_w2_s), 32'd1);
                end else begin
                    chk("m_wr_en_r1", 32'(en_r1_s), 32'd1);
                    chk("m_wr_en_r2", 32'(en_r2_s), 32'd1);
                    chk("m_wr_en_w1", 32'(en_w1_s), 32'd0);
                    chk("m_wr_addr_w1", 32'(addr_w1_s), 32'(lft));
                    chk("m_wr_data_w1", data_w1_s, fm(mid ? orig[lft] : orig[rgt], inv_m));
                    chk("m_wr_en_w2", 32'(en_w2_s), 32'(mid));
                    if (!mid) begin
                        chk("m_wr_addr_w2", 32'(addr_w2_s), 32'(rgt));
                        chk("m_wr_data_w2", data_w2_s, fm(orig[lft], inv_m));
                    end
                end
            end else if (t > 2 * np) begin
                chk("m_end_busy", 32'(busy_s), 32'd0);
                chk("m_end_done", 32'(done_s), 32'(t >= 2 * np + 2));
                chk("m_end_en", {28'd0, en_r1_s, en_r2_s, en_w1_s, en_w2_s}, 32'hF);
            end
        end
    end

    task automatic snap();
        for (int i = 0; i < 8; i++) orig[i] = mem[sel][i];
    endtask

    task automatic load_img(input logic [31:0] v [8]);
        for (int i = 0; i < 8; i++) img[i] = v[i];
        @(negedge clk);
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic do_start(input bit inv);
        @(negedge clk);
        invert_en = inv;
        inv_m = inv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        invert_en = !inv;   // must have no effect once latched
        k_cyc = cyc_all;
    endtask

    task automatic run_frame(input bit inv, input bit poke, output int busy_n, output int done_n);
        snap();
        do_start(inv);
        trk = 1'b1;
        busy_n = busy_s ? 1 : 0;
        done_n = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            start = poke && (n == 3);
            if (done_s) begin
                done_n = n;
                break;
            end
            if (busy_s) busy_n++;
        end
        start = 1'b0;
        if (done_n < 0) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1;
        trk = 1'b0;
    endtask

    task automatic chk_mem(input string nm, input logic [31:0] e [8], input int n);
        for (int i = 0; i < n; i++) chk($sformatf("%s_word%0d", nm, i), mem[sel][i], e[i]);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_busy"}, 32'(busy_s), 32'd0);
        chk({nm, "_done"}, 32'(done_s), 32'd0);
        chk({nm, "_en"}, {28'd0, en_r1_s, en_r2_s, en_w1_s, en_w2_s}, 32'hF);
    endtask

    logic [31:0] v [8];
    logic [31:0] e [8];
    int bn, dn;

    initial begin
        #2;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk_idle($sformatf("reset%0d", s));
            chk("reset_addr", {addr_r1_s, addr_r2_s, addr_w1_s, addr_w2_s}, 32'd0);
            chk("reset_data", data_w1_s | data_w2_s, 32'd0);
        end
        sel = 0;
        @(negedge clk);
        reset_n = 1'b1;

        // flip only, 4x2
        v = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
        load_img(v);
        run_frame(1'b0, 1'b0, bn, dn);
        e = '{32'h3, 32'h2, 32'h1, 32'h0, 32'h7, 32'h6, 32'h5, 32'h4};
        chk_mem("t1", e, 8);
        chk("t1_busy_cycles", 32'(bn), 32'd8);
        chk("t1_done_cycle", 32'(dn), 32'd9);
        chk("t1_done_held", 32'(done_s), 32'd1);

        // invert, upper byte cleared
        v = '{32'hFF102030, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
        load_img(v);
        run_frame(1'b1, 1'b0, bn, dn);
        chk("t2_word3", mem[0][3], 32'h00EFDFCF);
        chk("t2_word0", mem[0][0], 32'h00FFFFFC);
        chk("t2_done_cycle", 32'(dn), 32'd9);

        // start together with abort in IDLE is ignored
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        #1;
        chk("sa_busy", 32'(busy_s), 32'd0);
        chk("sa_en_r1", 32'(en_r1_s), 32'd1);

        // abort in RD of the third pair (row 1, col 0)
        v = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
        load_img(v);
        do_start(1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("ab_rd_en_r1", 32'(en_r1_s), 32'd0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk_idle("ab_rd");
        repeat (2) @(posedge clk);
        #1;
        e = '{32'h3, 32'h2, 32'h1, 32'h0, 32'h4, 32'h5, 32'h6, 32'h7};
        chk_mem("ab_rd", e, 8);

        // restart on the partially processed frame
        run_frame(1'b0, 1'b0, bn, dn);
        e = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h7, 32'h6, 32'h5, 32'h4};
        chk_mem("ab_restart", e, 8);
        chk("ab_restart_done_cycle", 32'(dn), 32'd9);

        // abort in WR of the first pair: that pair is still written
        load_img(v);
        do_start(1'b0);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk_idle("ab_wr");
        repeat (2) @(posedge clk);
        #1;
        e = '{32'h3, 32'h1, 32'h2, 32'h0, 32'h4, 32'h5, 32'h6, 32'h7};
        chk_mem("ab_wr", e, 8);

        // asynchronous reset mid-frame, then a full frame with a stray start
        load_img(v);
        do_start(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_idle("rst_mid");
        @(negedge clk);
        reset_n = 1'b1;
        run_frame(1'b0, 1'b1, bn, dn);
        chk("rst_restart_done_cycle", 32'(dn), 32'd9);
        chk("rst_restart_busy_cycles", 32'(bn), 32'd8);

        // odd width 5x1 with invert: middle pixel written to itself
        sel = 1;
        v = '{32'h11AA0001, 32'h22BB0002, 32'h33CC0003, 32'h44DD0004, 32'h55EE0005, 32'h0, 32'h0, 32'h0};
        load_img(v);
        run_frame(1'b1, 1'b0, bn, dn);
        e = '{32'h0011FFFA, 32'h0022FFFB, 32'h0033FFFC, 32'h0044FFFD, 32'h0055FFFE, 32'h0, 32'h0, 32'h0};
        chk_mem("t3", e, 5);
        chk("t3_done_cycle", 32'(dn), 32'd7);
        chk("t3_busy_cycles", 32'(bn), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
